// File: rtl/alu_ex_mdu_pkg.sv
// Shared control encodings for the execute-stage ALU/MDU: operation codes,
// MDU sequencer states and divide-by-zero policy.
package alu_ex_mdu_pkg;

   typedef enum logic [4:0] {
      OP_ADDU  = 5'd0,
      OP_SUBU  = 5'd1,
      OP_AND   = 5'd2,
      OP_OR    = 5'd3,
      OP_XOR   = 5'd4,
      OP_NOR   = 5'd5,
      OP_SLT   = 5'd6,
      OP_SLTU  = 5'd7,
      OP_SLL   = 5'd8,
      OP_SRL   = 5'd9,
      OP_SRA   = 5'd10,
      OP_SLLV  = 5'd11,
      OP_SRLV  = 5'd12,
      OP_SRAV  = 5'd13,
      OP_BNE   = 5'd14,
      OP_MFHI  = 5'd15,
      OP_MFLO  = 5'd16,
      OP_MULT  = 5'd17,
      OP_MULTU = 5'd18,
      OP_DIV   = 5'd19,
      OP_DIVU  = 5'd20
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } mdu_state_e;

   // Divide by zero: lo is filled with this bit, hi returns the dividend.
   localparam logic DIV0_LO_FILL = 1'b1;
   localparam logic DIV0_HI_IS_A = 1'b1;

endpackage

// File: rtl/alu_mdu_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider sharing one
// WIDTH-bit adder and one down-counter; operands are magnitudes.
module alu_mdu_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic             mode_div_i,
   input  logic [WIDTH-1:0] op_a_i,
   input  logic [WIDTH-1:0] op_b_i,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] ITERS = CW'(WIDTH);

   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
   logic             div_q, div_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] add_x, add_y;
   logic             add_ci;
   logic [WIDTH:0]   add_s;
   logic             div_ge;

   // Divide reuses the adder as x + ~d + 1; carry out means no borrow.
   always_comb begin
      if (div_q) begin
         add_x  = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
         add_y  = ~opb_q;
         add_ci = 1'b1;
      end else begin
         add_x  = hi_q;
         add_y  = lo_q[0] ? opb_q : '0;
         add_ci = 1'b0;
      end
   end

   assign add_s  = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_ci};
   // A bit shifted out of the remainder top means the trial value already exceeds the divisor.
   assign div_ge = hi_q[WIDTH-1] | add_s[WIDTH];

   always_comb begin
      hi_d  = hi_q;
      lo_d  = lo_q;
      opb_d = opb_q;
      div_d = div_q;
      cnt_d = cnt_q;
      if (abort_i) begin
         cnt_d = '0;
      end else if (start_i) begin
         hi_d  = '0;
         lo_d  = op_a_i;
         opb_d = op_b_i;
         div_d = mode_div_i;
         cnt_d = ITERS;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
         if (div_q) begin
            hi_d = div_ge ? add_s[WIDTH-1:0] : add_x;
            lo_d = {lo_q[WIDTH-2:0], div_ge};
         end else begin
            {hi_d, lo_d} = {add_s, lo_q[WIDTH-1:1]};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q  <= '0;
         lo_q  <= '0;
         opb_q <= '0;
         div_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         opb_q <= opb_d;
         div_q <= div_d;
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == CW'(1));
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;

endmodule

// File: rtl/alu_ex_mdu.sv
// Execute-stage ALU with single-cycle ops and an iterative multiply/divide
// unit that owns the architectural HI/LO registers.
//
// state   | meaning
// IDLE    | ready; single-cycle ops complete here
// MUL     | shift-add iterations in progress
// DIV     | restoring-divide iterations in progress
// DONE    | sign fix-up; hi/lo/result written on exit
module alu_ex_mdu #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             flush,
   input  logic [4:0]       alu_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [SHW-1:0]   shamt,
   input  logic [WIDTH-1:0] pc,
   input  logic [WIDTH-1:0] imm,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic [WIDTH-1:0] br_target,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   import alu_ex_mdu_pkg::*;

   mdu_state_e       state_q, state_d;
   logic             op_is_mul, op_is_div, op_signed, accept, iter_start, iter_done;
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag, alu_res, it_hi, it_lo, fin_hi, fin_lo;
   logic [SHW-1:0]   sh_v;
   logic [2*WIDTH-1:0] prod;

   logic [WIDTH-1:0] result_q, result_d, br_q, br_d, hi_q, hi_d, lo_q, lo_d, a_q, a_d;
   logic             zero_q, zero_d, out_valid_q, out_valid_d;
   logic             neg_q, neg_d, rem_neg_q, rem_neg_d, div0_q, div0_d, mdu_div_q, mdu_div_d;

   assign op_is_mul  = (alu_op == OP_MULT) || (alu_op == OP_MULTU);
   assign op_is_div  = (alu_op == OP_DIV)  || (alu_op == OP_DIVU);
   assign op_signed  = (alu_op == OP_MULT) || (alu_op == OP_DIV);
   assign accept     = in_valid && in_ready && !flush;
   assign iter_start = accept && (op_is_mul || op_is_div);

   assign a_neg = op_signed && a[WIDTH-1];
   assign b_neg = op_signed && b[WIDTH-1];
   assign a_mag = a_neg ? (~a + 1'b1) : a;
   assign b_mag = b_neg ? (~b + 1'b1) : b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept && op_is_mul)      state_d = ST_MUL;
            else if (accept && op_is_div) state_d = ST_DIV;
         end
         ST_MUL, ST_DIV: begin
            if (flush)          state_d = ST_IDLE;
            else if (iter_done) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state_q == ST_IDLE);
      busy     = (state_q != ST_IDLE);
   end

   alu_mdu_iter #(.WIDTH(WIDTH)) u_iter (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (iter_start),
      .abort_i    (flush),
      .mode_div_i (op_is_div),
      .op_a_i     (a_mag),
      .op_b_i     (b_mag),
      .done_o     (iter_done),
      .hi_o       (it_hi),
      .lo_o       (it_lo)
   );

   assign sh_v = a[SHW-1:0];

   always_comb begin
      alu_res = '0;
      case (alu_op)
         OP_ADDU: alu_res = a + b;
         OP_SUBU: alu_res = a - b;
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_XOR:  alu_res = a ^ b;
         OP_NOR:  alu_res = ~(a | b);
         OP_SLT:  alu_res[0] = $signed(a) < $signed(b);
         OP_SLTU: alu_res[0] = a < b;
         OP_SLL:  alu_res = b << shamt;
         OP_SRL:  alu_res = b >> shamt;
         OP_SRA:  alu_res = $signed(b) >>> shamt;
         OP_SLLV: alu_res = b << sh_v;
         OP_SRLV: alu_res = b >> sh_v;
         OP_SRAV: alu_res = $signed(b) >>> sh_v;
         OP_BNE:  alu_res[0] = (a != b);
         OP_MFHI: alu_res = hi_q;
         OP_MFLO: alu_res = lo_q;
         default: alu_res = '0;
      endcase
   end

   // Iterator works on magnitudes; signs are restored here during DONE.
   always_comb begin
      prod = neg_q ? -{it_hi, it_lo} : {it_hi, it_lo};
      if (!mdu_div_q) begin
         {fin_hi, fin_lo} = prod;
      end else if (div0_q) begin
         fin_lo = {WIDTH{DIV0_LO_FILL}};
         fin_hi = DIV0_HI_IS_A ? a_q : '0;
      end else begin
         fin_lo = neg_q     ? -it_lo : it_lo;
         fin_hi = rem_neg_q ? -it_hi : it_hi;
      end
   end

   always_comb begin
      result_d    = result_q;
      zero_d      = zero_q;
      br_d        = br_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      a_d         = a_q;
      neg_d       = neg_q;
      rem_neg_d   = rem_neg_q;
      div0_d      = div0_q;
      mdu_div_d   = mdu_div_q;
      out_valid_d = 1'b0;
      if (accept) begin
         br_d = pc + (imm << 2);
         if (op_is_mul || op_is_div) begin
            a_d       = a;
            neg_d     = a_neg ^ b_neg;
            rem_neg_d = a_neg;
            div0_d    = (b == '0);
            mdu_div_d = op_is_div;
         end else begin
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            out_valid_d = 1'b1;
         end
      end
      if (state_q == ST_DONE && !flush) begin
         hi_d        = fin_hi;
         lo_d        = fin_lo;
         result_d    = fin_lo;
         zero_d      = (fin_lo == '0);
         out_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q    <= '0;
         zero_q      <= 1'b0;
         br_q        <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         a_q         <= '0;
         neg_q       <= 1'b0;
         rem_neg_q   <= 1'b0;
         div0_q      <= 1'b0;
         mdu_div_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         result_q    <= result_d;
         zero_q      <= zero_d;
         br_q        <= br_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         a_q         <= a_d;
         neg_q       <= neg_d;
         rem_neg_q   <= rem_neg_d;
         div0_q      <= div0_d;
         mdu_div_q   <= mdu_div_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign zero      = zero_q;
   assign br_target = br_q;
   assign hi        = hi_q;
   assign lo        = lo_q;

endmodule

// File: tb/tb_alu_ex_mdu.sv
// Directed bench for alu_ex_mdu at WIDTH=32 plus a WIDTH=16 instance for the
// narrow multiply case.
module tb_alu_ex_mdu;
   import alu_ex_mdu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, flush, in_ready, out_valid, zero, busy;
   logic [4:0]  alu_op, shamt;
   logic [31:0] a, b, pc, imm, result, br_target, hi, lo;

   logic        s_in_valid, s_in_ready, s_out_valid, s_zero, s_busy;
   logic [4:0]  s_alu_op;
   logic [3:0]  s_shamt;
   logic [15:0] s_a, s_b, s_pc, s_imm, s_result, s_br_target, s_hi, s_lo;

   int checks = 0;
   int errors = 0;
   int n;
   logic seen;

   always #5 clk = ~clk;

   alu_ex_mdu #(.WIDTH(32)) u32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .flush(flush), .alu_op(alu_op), .a(a), .b(b), .shamt(shamt),
      .pc(pc), .imm(imm), .out_valid(out_valid), .result(result),
      .zero(zero), .br_target(br_target), .busy(busy), .hi(hi), .lo(lo)
   );

   alu_ex_mdu #(.WIDTH(16)) u16 (
      .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .flush(1'b0), .alu_op(s_alu_op), .a(s_a), .b(s_b), .shamt(s_shamt),
      .pc(s_pc), .imm(s_imm), .out_valid(s_out_valid), .result(s_result),
      .zero(s_zero), .br_target(s_br_target), .busy(s_busy), .hi(s_hi), .lo(s_lo)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic run_single(input string tag, input logic [4:0] op, input logic [31:0] av,
                             input logic [31:0] bv, input logic [4:0] sh,
                             input logic [31:0] exp_r, input logic exp_z);
      alu_op = op; a = av; b = bv; shamt = sh; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check({tag, " out_valid"}, 64'(out_valid), 64'd1);
      check({tag, " result"}, 64'(result), 64'(exp_r));
      check({tag, " zero"}, 64'(zero), 64'(exp_z));
   endtask

   // Holds an ADDU request during the operation; it must be ignored while not ready.
   task automatic run_multi(input string tag, input logic [4:0] op, input logic [31:0] av,
                            input logic [31:0] bv, input logic [31:0] exp_hi,
                            input logic [31:0] exp_lo);
      int cyc;
      logic bad;
      alu_op = op; a = av; b = bv; in_valid = 1'b1;
      @(posedge clk); #1;
      alu_op = OP_ADDU; a = 32'h1; b = 32'h1;
      cyc = 0; bad = 1'b0;
      while (out_valid !== 1'b1 && cyc < 80) begin
         if (in_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0;
      check({tag, " latency"}, 64'(cyc), 64'd33);
      check({tag, " stall"}, 64'(bad), 64'd0);
      check({tag, " hi"}, 64'(hi), 64'(exp_hi));
      check({tag, " lo"}, 64'(lo), 64'(exp_lo));
      check({tag, " result"}, 64'(result), 64'(exp_lo));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; alu_op = '0; shamt = '0;
      a = '0; b = '0; pc = '0; imm = '0;
      s_in_valid = 1'b0; s_alu_op = '0; s_shamt = '0; s_a = '0; s_b = '0;
      s_pc = '0; s_imm = '0;
      #12;
      check("rst out_valid", 64'(out_valid), 64'd0);
      check("rst result", 64'(result), 64'd0);
      check("rst zero", 64'(zero), 64'd0);
      check("rst br_target", 64'(br_target), 64'd0);
      check("rst hi", 64'(hi), 64'd0);
      check("rst lo", 64'(lo), 64'd0);
      check("rst busy", 64'(busy), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst in_ready", 64'(in_ready), 64'd1);

      run_single("addu wrap", OP_ADDU, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 1'b1);
      @(posedge clk); #1;
      check("addu pulse", 64'(out_valid), 64'd0);
      run_single("srav", OP_SRAV, 32'h4, 32'h8000_0000, 5'd0, 32'hF800_0000, 1'b0);
      run_single("srl", OP_SRL, 32'h4, 32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0);
      run_single("sra zero", OP_SRA, 32'h0, 32'h8000_0001, 5'd0, 32'h8000_0001, 1'b0);
      run_single("sll", OP_SLL, 32'h0, 32'h3, 5'd31, 32'h8000_0000, 1'b0);
      run_single("sllv", OP_SLLV, 32'h1F, 32'h1, 5'd0, 32'h8000_0000, 1'b0);
      run_single("srlv", OP_SRLV, 32'h24, 32'hF0, 5'd0, 32'hF, 1'b0);
      run_single("subu", OP_SUBU, 32'h3, 32'h5, 5'd0, 32'hFFFF_FFFE, 1'b0);
      run_single("slt", OP_SLT, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h1, 1'b0);
      run_single("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 1'b1);
      run_single("and", OP_AND, 32'hF0F0, 32'hFF00, 5'd0, 32'hF000, 1'b0);
      run_single("or", OP_OR, 32'hF0F0, 32'hFF00, 5'd0, 32'hFFF0, 1'b0);
      run_single("xor", OP_XOR, 32'hF0F0, 32'hFF00, 5'd0, 32'h0FF0, 1'b0);
      run_single("nor", OP_NOR, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFF, 1'b0);
      pc = 32'h0040_0000; imm = 32'hFFFF_FFFF;
      run_single("bne eq", OP_BNE, 32'h5, 32'h5, 5'd0, 32'h0, 1'b1);
      check("bne br_target", 64'(br_target), 64'h003F_FFFC);
      pc = 32'h0000_1000; imm = 32'h0000_0010;
      run_single("bne ne", OP_BNE, 32'h5, 32'h6, 5'd0, 32'h1, 1'b0);
      check("bne br_target fwd", 64'(br_target), 64'h0000_1040);
      run_single("undef op", 5'd31, 32'h7, 32'h7, 5'd0, 32'h0, 1'b1);

      run_multi("mult -3*7", OP_MULT, 32'hFFFF_FFFD, 32'h7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run_single("mfhi", OP_MFHI, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFF, 1'b0);
      run_single("mflo", OP_MFLO, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFEB, 1'b0);
      run_multi("multu 2^16*2^16", OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0);
      run_multi("mult -1*-1", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1);
      run_multi("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_multi("div 7/-2", OP_DIV, 32'h7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD);
      run_multi("divu 5/0", OP_DIVU, 32'h5, 32'h0, 32'h5, 32'hFFFF_FFFF);
      run_multi("div -5/0", OP_DIV, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
      run_multi("div min/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
      run_multi("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
      run_multi("divu big", OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 32'h1);

      alu_op = OP_DIVU; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      flush = 1'b1; in_valid = 1'b1; alu_op = OP_ADDU; a = 32'h1; b = 32'h1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      check("flush in_ready", 64'(in_ready), 64'd1);
      check("flush busy", 64'(busy), 64'd0);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid !== 1'b0) seen = 1'b1;
         @(posedge clk); #1;
      end
      check("flush no out_valid", 64'(seen), 64'd0);
      check("flush hi kept", 64'(hi), 64'h7FFF_FFFE);
      check("flush lo kept", 64'(lo), 64'h1);
      check("flush addu dropped", 64'(result), 64'h1);

      alu_op = OP_MULTU; a = 32'd5; b = 32'd5; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      check("midrst busy", 64'(busy), 64'd0);
      #2;
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) seen = 1'b1;
      end
      check("midrst no out_valid", 64'(seen), 64'd0);
      check("midrst lo", 64'(lo), 64'd0);
      check("midrst in_ready", 64'(in_ready), 64'd1);

      s_alu_op = OP_MULTU; s_a = 16'hFFFF; s_b = 16'hFFFF; s_in_valid = 1'b1;
      @(posedge clk); #1;
      s_in_valid = 1'b0;
      n = 0;
      while (s_out_valid !== 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check("w16 latency", 64'(n), 64'd17);
      check("w16 hi", 64'(s_hi), 64'hFFFE);
      check("w16 lo", 64'(s_lo), 64'h0001);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
